regdst_pipe: RTL
================

REGDST_PIPE -- requirements
Module: regdst_pipe

Interface
REQ-001 Parameter DW, default 32, datapath width of result/writeback data.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 id_valid  input  1  ID stage holds a real instruction.
REQ-005 id_rs, id_rt, id_rd  input  5 each  ID source/destination register numbers.
REQ-006 id_regwrite  input  1  ID instruction writes id_rd.
REQ-007 id_memread  input  1  ID instruction is a load.
REQ-008 flush  input  1  branch/jump taken; kill instruction entering EX.
REQ-009 ex_result  input  DW  EX-stage ALU result for the IDEX entry.
REQ-010 mem_rdata  input  DW  MEM-stage load data for the EXMEM entry.
REQ-011 stall  output  1  hold PC and IF/ID this cycle.
REQ-012 IDEX_Rs, IDEX_Rt  output  5 each  sources of the instruction in EX.
REQ-013 EXMEM_RegWrite, EXMEM_MemRead  output  1 each; EXMEM_Rd output 5; EXMEM_Data output DW.
REQ-014 MEMWB_RegWrite  output 1; MEMWB_Rd  output 5; MEMWB_Data  output DW (also the register-file write port).
REQ-015 stall_cnt  output  16  saturating count of load-use stall cycles.

Function
REQ-016 Three register stages ID/EX, EX/MEM, MEM/WB shall each advance one stage per clock; latency ID capture to MEMWB outputs = 3 cycles.
REQ-017 hazard = IDEX_MemRead & IDEX_RegWrite & (IDEX_Rd!=0) & id_valid & (IDEX_Rd==id_rs | IDEX_Rd==id_rt), computed from registered state only.
REQ-018 stall = hazard & !flush (combinational, no input-to-output path except via flush and id_* signals).
REQ-019 ID/EX shall load a bubble (all fields 0) when flush, stall, or !id_valid; otherwise load id_* fields.
REQ-020 On capture, RegWrite shall be forced 0 when id_rd==0; Rd then stored as 0.
REQ-021 EX/MEM and MEM/WB shall never stall; bubbles propagate unchanged.
REQ-022 EXMEM_Data <= ex_result; MEMWB_Data <= EXMEM_MemRead ? mem_rdata : EXMEM_Data; no width extension, exactly DW bits.
REQ-023 flush and hazard in same cycle: bubble inserted, stall=0, stall_cnt unchanged.
REQ-024 stall_cnt shall increment on each cycle with stall=1, saturating at 16'hFFFF.
REQ-025 Back-to-back load-use: at most one stall cycle per load, because the inserted bubble clears IDEX_MemRead.

Reset
REQ-026 rstn low shall immediately clear all stage fields, data registers and stall_cnt to 0; stall=0 while in reset.
REQ-027 Reset mid-operation discards all in-flight entries; first post-reset capture occurs on the first rising edge with rstn high.

Structure
REQ-028 Shared package: register-number width (5), ZERO_REG constant, bubble/stage-record typedef.
REQ-029 One sub-module, stage_reg (one pipeline stage register with load/bubble control), instantiated three times.

Verification
REQ-030 Reset: rstn=0 mid-stream -> all outputs 0 same cycle; after release, zeros until first valid instruction reaches each stage.
REQ-031 ALU chain: id_rd=5, regwrite=1, ex_result=32'h1234 -> EXMEM_Rd=5, EXMEM_Data=32'h1234 next cycle; MEMWB_Data=32'h1234 cycle after.
REQ-032 Load-use: load rd=8, next id_rs=8 -> stall=1 exactly one cycle, EXMEM_RegWrite=0 bubble behind load, stall_cnt=1; MEMWB_Data=mem_rdata (32'hCAFE).
REQ-033 Flush with hazard: flush=1 while hazard true -> stall=0, IDEX fields 0, stall_cnt unchanged.
REQ-034 rd=0 write: id_rd=0, regwrite=1 -> EXMEM_RegWrite=0, MEMWB_RegWrite=0.
REQ-035 Saturation: force 65540 hazard cycles -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/regdst_pipe_pkg.sv
// Shared definitions for the regdst_pipe ID/EX -> EX/MEM -> MEM/WB pipeline slice.
package regdst_pipe_pkg;

   localparam int RW = 5;
   localparam logic [RW-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic          regwrite;
      logic          memread;
      logic [RW-1:0] rd;
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
   } stage_ctrl_t;

   localparam stage_ctrl_t BUBBLE = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0};

   function automatic logic writes_reg(input logic regwrite, input logic [RW-1:0] rd);
      return regwrite && (rd != ZERO_REG);
   endfunction

endpackage

// File: rtl/regdst_pipe_stage_reg.sv
// One pipeline stage register: loads i_d each cycle, or an all-zero bubble when i_bubble is set.
module stage_reg #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         i_bubble,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Stage contents: async clear, then either a bubble or the incoming record.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_q <= {W{1'b0}};
      end else if (i_bubble) begin
         r_q <= {W{1'b0}};
      end else begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/regdst_pipe.sv
// Three-stage register-destination pipeline with load-use hazard detection and a stall counter.
module regdst_pipe
   import regdst_pipe_pkg::*;
#(
   parameter int          DW        = 32,
   parameter logic [15:0] STALL_SAT = 16'hFFFF
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          id_valid,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic          id_regwrite,
   input  logic          id_memread,
   input  logic          flush,
   input  logic [DW-1:0] ex_result,
   input  logic [DW-1:0] mem_rdata,
   output logic          stall,
   output logic [RW-1:0] IDEX_Rs,
   output logic [RW-1:0] IDEX_Rt,
   output logic          EXMEM_RegWrite,
   output logic          EXMEM_MemRead,
   output logic [RW-1:0] EXMEM_Rd,
   output logic [DW-1:0] EXMEM_Data,
   output logic          MEMWB_RegWrite,
   output logic [RW-1:0] MEMWB_Rd,
   output logic [DW-1:0] MEMWB_Data,
   output logic [15:0]   stall_cnt
);

   localparam int XW = 2 + RW + DW;
   localparam int WW = 1 + RW + DW;

   stage_ctrl_t   w_id_ctrl;
   stage_ctrl_t   w_idex;
   logic          w_hazard;
   logic          w_idex_bubble;
   logic [XW-1:0] w_exmem_d;
   logic [XW-1:0] w_exmem_q;
   logic [WW-1:0] w_memwb_d;
   logic [WW-1:0] w_memwb_q;
   logic [15:0]   r_stall_cnt;

   // Decoded ID record; a write to register 0 is dropped at capture.
   always_comb begin
      w_id_ctrl          = BUBBLE;
      w_id_ctrl.regwrite = writes_reg(id_regwrite, id_rd);
      w_id_ctrl.memread  = id_memread;
      w_id_ctrl.rd       = w_id_ctrl.regwrite ? id_rd : ZERO_REG;
      w_id_ctrl.rs       = id_rs;
      w_id_ctrl.rt       = id_rt;
   end

   assign w_hazard = w_idex.memread & w_idex.regwrite & (w_idex.rd != ZERO_REG) & id_valid &
                     ((w_idex.rd == id_rs) | (w_idex.rd == id_rt));
   assign stall         = w_hazard & ~flush;
   assign w_idex_bubble = flush | stall | ~id_valid;

   stage_reg #(.W($bits(stage_ctrl_t))) u_idex (
      .clk      (clk),
      .rstn     (rstn),
      .i_bubble (w_idex_bubble),
      .i_d      (w_id_ctrl),
      .o_q      (w_idex)
   );

   assign w_exmem_d = {w_idex.regwrite, w_idex.memread, w_idex.rd, ex_result};

   stage_reg #(.W(XW)) u_exmem (
      .clk      (clk),
      .rstn     (rstn),
      .i_bubble (1'b0),
      .i_d      (w_exmem_d),
      .o_q      (w_exmem_q)
   );

   assign {EXMEM_RegWrite, EXMEM_MemRead, EXMEM_Rd, EXMEM_Data} = w_exmem_q;
   assign w_memwb_d = {EXMEM_RegWrite, EXMEM_Rd, EXMEM_MemRead ? mem_rdata : EXMEM_Data};

   stage_reg #(.W(WW)) u_memwb (
      .clk      (clk),
      .rstn     (rstn),
      .i_bubble (1'b0),
      .i_d      (w_memwb_d),
      .o_q      (w_memwb_q)
   );

   assign {MEMWB_RegWrite, MEMWB_Rd, MEMWB_Data} = w_memwb_q;
   assign IDEX_Rs = w_idex.rs;
   assign IDEX_Rt = w_idex.rt;

   // Saturating count of cycles in which the load-use stall was actually applied.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_stall_cnt <= 16'd0;
      end else if (stall && (r_stall_cnt != STALL_SAT)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

   assign stall_cnt = r_stall_cnt;

endmodule
